// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Iterative 32x32 multiply / divide unit with HI/LO registers.
//                One shift-add (MULT/MULTU) or restoring shift-subtract
//                (DIV/DIVU) step per cycle; fixed 33-edge latency.
//                MTHI/MTLO write HI/LO directly without occupying the unit.
//  Ports       : clk     - clock, rising edge
//                rst_n   - synchronous active-low reset
//                A_data  - operand A (dividend / multiplicand, MTHI/MTLO data)
//                B_data  - operand B (divisor / multiplier)
//                op      - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                          100 MTHI, 101 MTLO, 11x no-op
//                start   - request, sampled only while idle
//                flush   - abort in-flight operation / drop idle request
//                busy    - unit occupied
//                done    - one-cycle pulse when HI/LO take a MULT/DIV result
//                hi, lo  - HI / LO registers
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A_data,
    input  logic [31:0] B_data,
    input  logic [2:0]  op,
    input  logic        start,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] c_op_mthi   = 3'b100;
    localparam logic [2:0] c_op_mtlo   = 3'b101;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_calc   = 2'd1;
    localparam logic [1:0] c_st_final  = 2'd2;

    // Counter value seen on the edge that completes the 32nd step.
    localparam logic [5:0] c_last_step = 6'd31;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [5:0]  r_cnt;
    logic [63:0] r_acc;       // {partial product / remainder, multiplier / quotient}
    logic [31:0] r_opnd;      // multiplicand or divisor magnitude
    logic        r_is_div;
    logic        r_neg_lo;    // product sign (mult) or quotient sign (div)
    logic        r_neg_hi;    // remainder sign = dividend sign
    logic        r_div_zero;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_nxt;
    logic [32:0] w_div_top;
    logic        w_div_ge;
    logic [31:0] w_div_diff;
    logic [63:0] w_div_nxt;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign busy = (r_state != c_st_idle);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

    // Only MULT/MULTU/DIV/DIVU (op[2]=0) occupy the unit.
    assign w_accept = (r_state == c_st_idle) && start && !flush && !op[2];

    // Work on magnitudes; signs are reapplied in FINAL.
    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & A_data[31];
    assign w_b_neg  = w_signed & B_data[31];
    assign w_a_mag  = w_a_neg ? (32'd0 - A_data) : A_data;
    assign w_b_mag  = w_b_neg ? (32'd0 - B_data) : B_data;

    // Shift-add: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
    assign w_mul_nxt = {w_mul_sum, r_acc[31:1]};

    // Restoring divide: shift left, try subtracting the divisor from the
    // upper part; the quotient bit enters at the bottom. When the subtract
    // succeeds the difference is below the divisor, so 32 bits suffice.
    assign w_div_top  = r_acc[63:31];
    assign w_div_ge   = (w_div_top >= {1'b0, r_opnd});
    assign w_div_diff = w_div_top[31:0] - r_opnd;
    assign w_div_nxt  = {(w_div_ge ? w_div_diff : w_div_top[31:0]), r_acc[30:0], w_div_ge};

    // Sign correction. Divide by zero yields an all-ones quotient; the
    // remainder is |A| re-signed with A's sign, which is A itself.
    assign w_prod = r_neg_lo ? (64'd0 - r_acc) : r_acc;
    assign w_quot = r_div_zero ? 32'hFFFF_FFFF :
                    (r_neg_lo ? (32'd0 - r_acc[31:0]) : r_acc[31:0]);
    assign w_rem  = r_neg_hi ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_accept) w_state_nxt = c_st_calc;
            c_st_calc:  if (r_cnt == c_last_step) w_state_nxt = c_st_final;
            c_st_final: w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
        if (flush) begin
            w_state_nxt = c_st_idle;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= 6'd0;
            r_acc      <= 64'd0;
            r_opnd     <= 32'd0;
            r_is_div   <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_div_zero <= 1'b0;
            r_done     <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
        end else begin
            r_done <= 1'b0;
            if (!flush) begin
                case (r_state)
                    c_st_idle: begin
                        if (w_accept) begin
                            r_cnt      <= 6'd0;
                            r_is_div   <= op[1];
                            r_neg_lo   <= w_a_neg ^ w_b_neg;
                            r_neg_hi   <= w_a_neg;
                            r_div_zero <= op[1] && (B_data == 32'd0);
                            r_acc      <= {32'd0, (op[1] ? w_a_mag : w_b_mag)};
                            r_opnd     <= op[1] ? w_b_mag : w_a_mag;
                        end else if (start && (op == c_op_mthi)) begin
                            r_hi <= A_data;
                        end else if (start && (op == c_op_mtlo)) begin
                            r_lo <= A_data;
                        end
                    end
                    c_st_calc: begin
                        r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
                        r_cnt <= r_cnt + 6'd1;
                    end
                    c_st_final: begin
                        r_done <= 1'b1;
                        if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end else begin
                            r_hi <= w_prod[63:32];
                            r_lo <= w_prod[31:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32 bits (HI/LO 32 each).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 A_data  input  32  operand A (rs); dividend or multiplicand.
REQ-005 B_data  input  32  operand B (rt), taken from the mux_B output; divisor or multiplier.
REQ-006 op  input  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are no-ops.
REQ-007 start  input  1  request; sampled only while busy=0.
REQ-008 flush  input  1  abort of any in-flight operation (pipeline flush).
REQ-009 busy  output  1  high while an operation occupies the unit.
REQ-010 done  output  1  one-cycle pulse when HI/LO take a new MULT/DIV result.
REQ-011 hi  output  32  HI register, registered output.
REQ-012 lo  output  32  LO register, registered output.

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC and FINAL.
REQ-014 In IDLE with start=1 and op in {MULT, MULTU, DIV, DIVU}, the block SHALL latch the operand magnitudes and the result signs, clear the 6-bit iteration counter, and go to CALC; this edge is E0.
REQ-015 In IDLE with start=1 and op=MTHI or op=MTLO, hi or lo respectively SHALL take A_data at E0; the block SHALL stay in IDLE, with busy=0 and done=0.
REQ-016 In IDLE with start=1 and op=110 or 111, the block SHALL do nothing.
REQ-017 CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle over edges E1..E32; the counter SHALL reach 32 and the FSM SHALL move to FINAL at E32.
REQ-018 FINAL: at E33 the block SHALL apply sign correction, write hi/lo, and return to IDLE; done=1 and busy=0 for exactly the cycle after E33.
REQ-019 Latency SHALL be 33 edges from start to result, fixed and independent of operand values.
REQ-020 busy SHALL be 1 from the cycle after E0 through the cycle ending at E33.
REQ-021 MULT/MULTU SHALL produce the full 64-bit product: hi = product[63:32], lo = product[31:0]; MULT is two's complement, MULTU is unsigned.
REQ-022 DIV/DIVU SHALL produce lo = quotient and hi = remainder.
REQ-023 Signed DIV SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-024 Divide by zero (B_data=0 at E0) SHALL still take 33 edges and give lo=0xFFFFFFFF and hi=A_data.
REQ-025 DIV with 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000.
REQ-026 start while busy=1 SHALL be ignored: no requeue, and the operands in flight are unaffected.
REQ-027 flush=1 in CALC or FINAL SHALL force IDLE on that edge, with hi/lo unchanged, done=0 and busy=0 the next cycle.
REQ-028 flush=1 in IDLE SHALL take priority over start, so an MTHI/MTLO or a new start on that edge is dropped.
REQ-029 Operand inputs SHALL be sampled only at E0; later changes on A_data/B_data SHALL have no effect.

Reset
REQ-030 With rst_n=0 at a rising edge the block SHALL return to IDLE, with hi=0, lo=0, busy=0, done=0 and the counter and internal operand registers cleared.
REQ-031 Reset SHALL dominate flush and start on the same edge.
REQ-032 Reset mid-CALC SHALL discard the operation with no done pulse.
REQ-033 Outputs SHALL not change between edges (no asynchronous path from rst_n).

Verification
REQ-034 MULT A=0xFFFFFFFE (-2), B=0x00000003 -> after 33 edges done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high for exactly 33 cycles.
REQ-035 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 DIV A=0xFFFFFFF9 (-7), B=0x00000002 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 7/0 -> lo=0xFFFFFFFF, hi=0x00000007.
REQ-037 DIVU 100/7 is started; start with MULT pulses at E5; flush=1 at E10 -> no done, hi/lo keep their prior values, busy=0 from the cycle after E10; a new DIVU 100/7 then gives lo=14, hi=2.
REQ-038 MTHI A=0x12345678 then MTLO A=0x9ABCDEF0 on back-to-back cycles -> hi/lo update on the following edges with busy and done never asserted.
REQ-039 rst_n=0 at E20 of a MULT -> hi=lo=0, busy=0, no done; a start on the edge after reset is accepted normally.
